pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 177 +++++++++++++++++
 tb/tb_pwm_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM duty/period decoder with stuck-line timeout.
// Optional 3-sample majority input filter enabled by defining PWMCAP_FILTER_EN.
module pwm_capture #(
  parameter int unsigned PRESC   = 16,
  parameter int unsigned PER_NOM = 256,
  parameter int unsigned PER_TOL = 4,
  parameter int unsigned TIMEOUT = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PWM,
  output logic [7:0] DutyDat,
  output logic       DutyVld,
  output logic       PerErr,
  output logic       Stuck
);

  localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc_cnt;
  logic          tick;
  logic          s1, s2, line, line_d;
  logic [2:0]    warm;
  logic          warm_done, rise, fall, edge_any;
  logic [9:0]    high_cnt, per_cnt, idle_cnt, high_nx, per_nx;
  logic          armed, timeout_hit, publish, start;
  logic [31:0]   per_w;
  logic          per_err_calc;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == '1) ? v : v + 10'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_cnt <= '0;
    end else if (presc_cnt == PW'(PRESC - 1)) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  assign tick = (presc_cnt == PW'(PRESC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= PWM;
      s2 <= s1;
    end
  end

`ifdef PWMCAP_FILTER_EN
  localparam logic [2:0] WARM = 3'd6;
  logic f0, f1, filt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      f0   <= 1'b0;
      f1   <= 1'b0;
      filt <= 1'b0;
    end else begin
      f0   <= s2;
      f1   <= f0;
      filt <= (s2 & f0) | (s2 & f1) | (f0 & f1);
    end
  end

  assign line = filt;
`else
  localparam logic [2:0] WARM = 3'd3;
  assign line = s2;
`endif

  // Edges are ignored until the input pipeline holds real samples, so a line
  // already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      line_d <= 1'b0;
      warm   <= '0;
    end else begin
      line_d <= line;
      if (warm != WARM) warm <= warm + 3'd1;
    end
  end

  assign warm_done = (warm == WARM);
  assign rise      = warm_done & line & ~line_d;
  assign fall      = warm_done & ~line & line_d;
  assign edge_any  = rise | fall;

  // A tick on the transition clk is credited to the state being left.
  assign high_nx     = (tick && state == HIGH) ? sat_inc(high_cnt) : high_cnt;
  assign per_nx      = (tick && state != IDLE) ? sat_inc(per_cnt) : per_cnt;
  assign timeout_hit = armed & tick & ~edge_any & (idle_cnt == 10'(TIMEOUT - 1));

  always_comb begin
    per_w        = 32'(per_nx);
    per_err_calc = (per_w > PER_NOM + PER_TOL) || (per_w + PER_TOL < PER_NOM);
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    publish = 1'b0;
    start   = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_n = HIGH;
        start   = 1'b1;
      end
      HIGH: if (fall) state_n = LOW;
      LOW: if (rise) begin
        state_n = HIGH;
        start   = 1'b1;
        publish = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (timeout_hit) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      high_cnt <= '0;
      per_cnt  <= '0;
      idle_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      if (start) begin
        high_cnt <= '0;
        per_cnt  <= '0;
      end else begin
        high_cnt <= high_nx;
        per_cnt  <= per_nx;
      end
      if (edge_any)  idle_cnt <= '0;
      else if (tick) idle_cnt <= sat_inc(idle_cnt);
      // Disarming after a timeout keeps a static line from re-firing.
      if (edge_any)         armed <= 1'b1;
      else if (timeout_hit) armed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      DutyDat <= '0;
      DutyVld <= 1'b0;
      PerErr  <= 1'b0;
      Stuck   <= 1'b0;
    end else begin
      DutyVld <= 1'b0;
      if (publish) begin
        DutyDat <= (high_cnt > 10'd255) ? 8'hFF : high_cnt[7:0];
        PerErr  <= per_err_calc;
        Stuck   <= 1'b0;
        DutyVld <= 1'b1;
      end else if (timeout_hit) begin
        DutyDat <= line ? '1 : '0;
        PerErr  <= 1'b0;
        Stuck   <= 1'b1;
        DutyVld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (fast prescaler, default thresholds).
module tb_pwm_capture;

  localparam int unsigned PRESC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       PWM = 1'b0;
  logic [7:0] DutyDat;
  logic       DutyVld, PerErr, Stuck;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;
  int unsigned t_edge;

  typedef struct {
    logic [7:0]  dat;
    logic        err;
    logic        stuck;
    int unsigned at;
  } pub_t;

  pub_t pubs[$];
  pub_t p;

  pwm_capture #(.PRESC(PRESC)) dut (
    .clk(clk), .rst(rst), .PWM(PWM),
    .DutyDat(DutyDat), .DutyVld(DutyVld), .PerErr(PerErr), .Stuck(Stuck)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (DutyVld === 1'b1) pubs.push_back('{DutyDat, PerErr, Stuck, cyc});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic hold(input logic lvl, input int unsigned ticks);
    PWM = lvl;
    repeat (ticks * PRESC) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] got,
                             input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    assert (((got >= lo) && (got <= hi)) === 1'b1) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic check_pub(input string tag, input logic [7:0] d, input logic e, input logic s);
    pub_t q;
    check({tag, "_avail"}, 32'(pubs.size() > 0), 1);
    if (pubs.size() > 0) begin
      q = pubs.pop_front();
      check({tag, "_dat"}, 32'(q.dat), 32'(d));
      check({tag, "_err"}, 32'(q.err), 32'(e));
      check({tag, "_stuck"}, 32'(q.stuck), 32'(s));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dat", 32'(DutyDat), 0);
    check("rst_vld", 32'(DutyVld), 0);
    check("rst_err", 32'(PerErr), 0);
    check("rst_stuck", 32'(Stuck), 0);
    rst = 1'b1;

    // 50% duty, nominal period
    hold(1'b0, 10);
    repeat (4) begin
      hold(1'b1, 128);
      hold(1'b0, 128);
    end
    hold(1'b1, 255);
    check("p50_count", 32'(pubs.size()), 4);
    repeat (4) check_pub("p50", 8'd128, 1'b0, 1'b0);

    // extreme duties
    hold(1'b0, 1);
    hold(1'b1, 1);
    hold(1'b0, 255);
    hold(1'b1, 150);
    check_pub("d255", 8'd255, 1'b0, 1'b0);
    check_pub("d1", 8'd1, 1'b0, 1'b0);

    // period tolerance
    hold(1'b0, 150);
    hold(1'b1, 129);
    check_pub("per300", 8'd150, 1'b1, 1'b0);
    hold(1'b0, 129);
    hold(1'b1, 50);
    check_pub("per258", 8'd129, 1'b0, 1'b0);

    // stuck low
    t_edge = cyc;
    hold(1'b0, 600);
    check("to_lo_count", 32'(pubs.size()), 1);
    if (pubs.size() > 0) check_range("to_lo_time", pubs[0].at - t_edge, 2048, 2051);
    check_pub("to_lo", 8'd0, 1'b0, 1'b1);
    check("to_lo_hold_dat", 32'(DutyDat), 0);

    // stuck high; a rise from IDLE does not publish or clear Stuck
    t_edge = cyc;
    hold(1'b1, 10);
    check("stuck_after_rise", 32'(Stuck), 1);
    hold(1'b1, 590);
    check("to_hi_count", 32'(pubs.size()), 1);
    if (pubs.size() > 0) check_range("to_hi_time", pubs[0].at - t_edge, 2048, 2051);
    check_pub("to_hi", 8'd255, 1'b0, 1'b1);

    hold(1'b0, 20);
    hold(1'b1, 100);
    hold(1'b0, 156);
    check("stuck_hold", 32'(Stuck), 1);
    check("stuck_hold_dat", 32'(DutyDat), 255);
    check("recover_none", 32'(pubs.size()), 0);

    // recovery publish, then a 1-clk low glitch mid-high
    hold(1'b1, 50);
    check_pub("recover", 8'd100, 1'b0, 1'b0);
    PWM = 1'b0;
    @(negedge clk);
    PWM = 1'b1;
    repeat (50 * PRESC - 1) @(negedge clk);
    hold(1'b0, 156);
    hold(1'b1, 40);
`ifdef PWMCAP_FILTER_EN
    check("glitch_count", 32'(pubs.size()), 1);
    check_pub("glitch", 8'd100, 1'b0, 1'b0);
`else
    check("glitch_count", 32'(pubs.size()), 2);
    check_pub("glitch_a", 8'd50, 1'b1, 1'b0);
    if (pubs.size() > 0) begin
      p = pubs.pop_front();
      check_range("glitch_b_dat", 32'(p.dat), 49, 50);
      check("glitch_b_err", 32'(p.err), 1);
    end
`endif

    // reset during HIGH discards the partial period
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_dat", 32'(DutyDat), 0);
    check("mid_rst_vld", 32'(DutyVld), 0);
    check("mid_rst_err", 32'(PerErr), 0);
    check("mid_rst_stuck", 32'(Stuck), 0);
    rst = 1'b1;
    hold(1'b1, 88);
    hold(1'b0, 128);
    check("post_rst_none", 32'(pubs.size()), 0);
    hold(1'b1, 128);
    hold(1'b0, 128);
    check("post_rst_first_none", 32'(pubs.size()), 0);
    PWM = 1'b1;
    repeat (8) @(negedge clk);
    check_pub("post_rst", 8'd128, 1'b0, 1'b0);
    check("post_rst_extra", 32'(pubs.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
